count_sequencer: RTL and testbench
==================================

# count_sequencer

Controller that sequences an 8-bit step counter through a bounded run. On a start command it latches a configuration (start value, step, tick count, speed), loads the counter, advances it by `step` on every divided-clock tick, and stops after `limit` ticks with a one-cycle `done` pulse. It sits between the front-panel or host command logic and the counter display path, replacing free-running count-by-step with a scheduled, abortable run.

## Interface
- `DIV_FAST`, 250000, tick period in `clk` cycles when speed=1; 1..2^26
- `DIV_SLOW`, 25000000, tick period in `clk` cycles when speed=0; 1..2^26
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  start request; sampled only in IDLE
- `abort`  in  1  cancel run; effective in LOAD/RUN only
- `speed`  in  1  1 = DIV_FAST, 0 = DIV_SLOW; latched at start
- `start_value`  in  8  initial count; latched at start
- `step`  in  8  increment per tick; latched at start
- `limit`  in  8  ticks per run; latched at start; 0 allowed
- `count`  out  8  current counter value
- `tick`  out  1  one-cycle pulse, high in the cycle count shows a new value
- `busy`  out  1  high whenever state != IDLE
- `done`  out  1  one-cycle pulse on normal completion
- `wrap`  out  1  sticky; set when any tick's count+step carries out of bit 7

## Operation
- States: IDLE, LOAD, RUN, DONE. Reset → IDLE; count, tick, busy, done, wrap, divider, tick counter, latched config all 0.
- IDLE: start=1 → latch config, → LOAD. abort ignored.
- LOAD (1 cycle): count ← start_value, wrap ← 0, div_cnt ← 0, tick_cnt ← 0. Next state RUN; DONE if latched limit=0; IDLE if abort.
- RUN: div_cnt increments each cycle. On the edge where div_cnt = DIV−1: div_cnt ← 0, count ← (count+step) mod 256, tick ← 1, tick_cnt ← tick_cnt+1, wrap ← wrap | carry. If that was the limit-th tick → DONE.
- RUN with abort=1 → IDLE; no count update, no tick, no done, even when abort coincides with a tick edge (abort wins).
- DONE (1 cycle): done=1, → IDLE. start ignored.
- count and wrap hold after DONE or abort until the next LOAD or reset.
- Inputs other than start/abort are don't-care outside the IDLE start cycle.
- DIV = DIV_FAST if latched speed else DIV_SLOW; divider is 26 bits.

## Timing
- Edge 0: start sampled in IDLE → LOAD, busy=1.
- Edge 1: count=start_value, state RUN (or DONE if limit=0).
- Tick k (1..limit) occurs at edge 1 + k·DIV; tick high for the following cycle only.
- Final tick edge 1 + limit·DIV → DONE; done high for one cycle; next edge → IDLE, busy=0.
- limit=0: done high after edge 1, IDLE after edge 2; no tick.
- Earliest restart: start sampled on the first IDLE edge after DONE/abort.
- Reset assertion clears all state and outputs immediately, with no clock edge required, in any state including mid-RUN; outputs stay 0 while rst=1.

## Test plan
- DIV_FAST=4, speed=1, start_value=10, step=3, limit=4 → count 10,13,16,19,22 at edges 1,5,9,13,17; tick pulses at each update; done one cycle after edge 17; count holds 22; wrap=0.
- start_value=250, step=10, limit=2 → count 4 at first tick with wrap=1, then 14; wrap stays 1 after done; next run with no carry clears wrap at LOAD.
- limit=0, start_value=77 → count=77 after edge 1, done for one cycle, no tick, busy low after edge 2.
- start_value=0, step=1, limit=5: abort asserted on the 3rd tick edge → count stays 2, no tick, no done, IDLE next cycle; start pulses and changed step/value during RUN have no effect.
- DIV_SLOW=10, speed=0, step=1, limit=3 → ticks every 10 cycles. Assert rst asynchronously mid-RUN → count, busy, wrap, tick, done 0 before next clk edge; start after release runs normally.

Source files
------------

// File: rtl/count_sequencer.sv
// Bounded-run step counter: latches a run configuration on start, advances the
// count by step on each divided-clock tick and stops after limit ticks.
module count_sequencer #(
    parameter int unsigned DIV_FAST = 250000,
    parameter int unsigned DIV_SLOW = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       speed,
    input  logic [7:0] start_value,
    input  logic [7:0] step,
    input  logic [7:0] limit,
    output logic [7:0] count,
    output logic       tick,
    output logic       busy,
    output logic       done,
    output logic       wrap
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    localparam logic [25:0] DivFastMax = 26'(DIV_FAST - 1);
    localparam logic [25:0] DivSlowMax = 26'(DIV_SLOW - 1);

    state_e      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic        tick_q, tick_d;
    logic        done_q, done_d;
    logic        wrap_q, wrap_d;
    logic [25:0] div_cnt_q, div_cnt_d;
    logic [7:0]  tick_cnt_q, tick_cnt_d;
    logic        speed_q, speed_d;
    logic [7:0]  start_value_q, start_value_d;
    logic [7:0]  step_q, step_d;
    logic [7:0]  limit_q, limit_d;

    logic [25:0] div_max;
    logic [8:0]  sum;
    logic [7:0]  tick_cnt_inc;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        tick_d        = 1'b0;
        done_d        = 1'b0;
        wrap_d        = wrap_q;
        div_cnt_d     = div_cnt_q;
        tick_cnt_d    = tick_cnt_q;
        speed_d       = speed_q;
        start_value_d = start_value_q;
        step_d        = step_q;
        limit_d       = limit_q;
        div_max       = speed_q ? DivFastMax : DivSlowMax;
        // Ninth bit is the carry out of bit 7 that feeds the sticky wrap flag.
        sum           = {1'b0, count_q} + {1'b0, step_q};
        tick_cnt_inc  = tick_cnt_q + 8'd1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    speed_d       = speed;
                    start_value_d = start_value;
                    step_d        = step;
                    limit_d       = limit;
                    state_d       = StLoad;
                end
            end
            StLoad: begin
                count_d    = start_value_q;
                wrap_d     = 1'b0;
                div_cnt_d  = '0;
                tick_cnt_d = '0;
                if (abort) begin
                    state_d = StIdle;
                end else if (limit_q == 8'd0) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Abort takes priority even over a coinciding tick edge.
                if (abort) begin
                    state_d = StIdle;
                end else if (div_cnt_q == div_max) begin
                    div_cnt_d  = '0;
                    count_d    = sum[7:0];
                    tick_d     = 1'b1;
                    tick_cnt_d = tick_cnt_inc;
                    wrap_d     = wrap_q | sum[8];
                    if (tick_cnt_inc == limit_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 26'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            count_q       <= '0;
            tick_q        <= 1'b0;
            done_q        <= 1'b0;
            wrap_q        <= 1'b0;
            div_cnt_q     <= '0;
            tick_cnt_q    <= '0;
            speed_q       <= 1'b0;
            start_value_q <= '0;
            step_q        <= '0;
            limit_q       <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            tick_q        <= tick_d;
            done_q        <= done_d;
            wrap_q        <= wrap_d;
            div_cnt_q     <= div_cnt_d;
            tick_cnt_q    <= tick_cnt_d;
            speed_q       <= speed_d;
            start_value_q <= start_value_d;
            step_q        <= step_d;
            limit_q       <= limit_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign done  = done_q;
    assign wrap  = wrap_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with small dividers (fast=4, slow=10).
module tb_count_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       speed;
    logic [7:0] start_value;
    logic [7:0] step;
    logic [7:0] limit;
    logic [7:0] count;
    logic       tick;
    logic       busy;
    logic       done;
    logic       wrap;

    int n_total = 0;
    int n_pass  = 0;

    count_sequencer #(
        .DIV_FAST(4),
        .DIV_SLOW(10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .speed      (speed),
        .start_value(start_value),
        .step       (step),
        .limit      (limit),
        .count      (count),
        .tick       (tick),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e_count, input logic e_tick,
                           input logic e_busy, input logic e_done, input logic e_wrap);
        chk({tag, ".count"}, 32'(count), 32'(e_count));
        chk({tag, ".tick"},  32'(tick),  32'(e_tick));
        chk({tag, ".busy"},  32'(busy),  32'(e_busy));
        chk({tag, ".done"},  32'(done),  32'(e_done));
        chk({tag, ".wrap"},  32'(wrap),  32'(e_wrap));
    endtask

    task automatic launch(input logic spd, input logic [7:0] sv, input logic [7:0] st,
                          input logic [7:0] lim);
        speed       = spd;
        start_value = sv;
        step        = st;
        limit       = lim;
        start       = 1'b1;
        edges(1);
        start       = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; speed = 1'b0;
        start_value = '0; step = '0; limit = '0;
        edges(2);
        chk_out("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        edges(1);
        chk_out("idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Run 1: 10 + 3 per tick, four ticks, DIV=4.
        launch(1'b1, 8'd10, 8'd3, 8'd4);
        chk_out("r1_load", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        edges(1);
        chk_out("r1_e1", 8'd10, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            edges(3);
            chk("r1_pre.count", 32'(count), 32'(10 + 3 * (k - 1)));
            chk("r1_pre.tick", 32'(tick), 32'd0);
            edges(1);
            chk("r1_tick.count", 32'(count), 32'(10 + 3 * k));
            chk("r1_tick.tick", 32'(tick), 32'd1);
            chk("r1_tick.done", 32'(done), (k == 4) ? 32'd1 : 32'd0);
        end
        edges(1);
        chk_out("r1_idle", 8'd22, 1'b0, 1'b0, 1'b0, 1'b0);

        // Run 2: carry out on the first tick.
        launch(1'b1, 8'd250, 8'd10, 8'd2);
        edges(1);
        chk_out("r2_e1", 8'd250, 1'b0, 1'b1, 1'b0, 1'b0);
        edges(4);
        chk_out("r2_t1", 8'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        edges(4);
        chk_out("r2_t2", 8'd14, 1'b1, 1'b1, 1'b1, 1'b1);
        edges(1);
        chk_out("r2_idle", 8'd14, 1'b0, 1'b0, 1'b0, 1'b1);

        // Next run without carry clears wrap at LOAD.
        launch(1'b1, 8'd5, 8'd1, 8'd1);
        edges(1);
        chk_out("r2b_e1", 8'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        edges(4);
        chk_out("r2b_t1", 8'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        edges(1);

        // Run 3: limit 0.
        launch(1'b1, 8'd77, 8'd9, 8'd0);
        edges(1);
        chk_out("r3_e1", 8'd77, 1'b0, 1'b1, 1'b1, 1'b0);
        edges(1);
        chk_out("r3_e2", 8'd77, 1'b0, 1'b0, 1'b0, 1'b0);

        // Run 4: abort on the third tick edge; RUN-time input changes ignored.
        launch(1'b1, 8'd0, 8'd1, 8'd5);
        edges(1);
        start = 1'b1; step = 8'd7; start_value = 8'd99;
        edges(4);
        start = 1'b0;
        chk_out("r4_t1", 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        edges(4);
        chk_out("r4_t2", 8'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        edges(3);
        abort = 1'b1;
        edges(1);
        abort = 1'b0;
        chk_out("r4_abort", 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        edges(5);
        chk_out("r4_hold", 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Run 5: slow divider, asynchronous reset mid-RUN.
        launch(1'b0, 8'd0, 8'd1, 8'd3);
        edges(1);
        chk_out("r5_e1", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        edges(9);
        chk("r5_pre.count", 32'(count), 32'd0);
        edges(1);
        chk_out("r5_t1", 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        edges(10);
        chk_out("r5_t2", 8'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_out("r5_async", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        edges(2);
        chk_out("r5_hold_rst", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        edges(1);

        // Run 6: normal run after reset release, slow divider with carry.
        launch(1'b0, 8'd200, 8'd100, 8'd1);
        edges(1);
        chk_out("r6_e1", 8'd200, 1'b0, 1'b1, 1'b0, 1'b0);
        edges(10);
        chk_out("r6_t1", 8'd44, 1'b1, 1'b1, 1'b1, 1'b1);
        edges(1);
        chk_out("r6_idle", 8'd44, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
